// File: rtl/clk_div_pkg.sv
// Shared width constants and ratio helpers for the clock-enable generator.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package clk_div_pkg;

    // Ratio width used when the top is left at its default.
    localparam int DIV_W_DEF = 8;

    // Widest ratio the helpers accept; channel widths must not exceed this.
    localparam int DIV_MAX_W = 16;

    typedef logic [DIV_MAX_W-1:0] div_t;
    typedef logic [DIV_MAX_W:0]   half_t;

    // ceil(d/2), computed one bit wider so d = all-ones cannot overflow.
    function automatic half_t half_up(input div_t d);
        return (half_t'(d) + half_t'(1)) >> 1;
    endfunction

    // A ratio of zero is meaningless; run it as divide-by-one.
    function automatic div_t sanitize(input div_t d);
        return (d == '0) ? div_t'(1) : d;
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: phase counter, active/pending ratio, registered strobe and square wave.
// Latency: outputs are registered, one cycle after the edge that computes them.
// Backpressure: none; en freezes the phase, sync forces phase 0, writes are queued until the period boundary.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int DIV_W   = DIV_W_DEF,
    parameter int DEF_DIV = 4
) (
    input  logic             in_clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             cfg_we,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_pend,
    output logic             ce_out,
    output logic             div_out
);

    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
    localparam logic [DIV_W-1:0] DEF_VAL = DIV_W'(DEF_DIV);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] act_q, act_d;
    logic [DIV_W-1:0] pnd_q, pnd_d;
    logic             pflag_q, pflag_d;
    logic             ce_q, ce_d;
    logic             div_q, div_d;

    logic [DIV_W-1:0] new_div;
    half_t            half_w;
    logic             term;

    assign new_div = DIV_W'(sanitize(DIV_MAX_W'(cfg_div)));
    assign half_w  = half_up(DIV_MAX_W'(act_q));
    assign term    = (cnt_q == act_q - ONE);

    // Next-state: sync re-phases, enabled edges count, and ratio swaps only at a boundary.
    always_comb begin
        cnt_d   = cnt_q;
        act_d   = act_q;
        pnd_d   = pnd_q;
        pflag_d = pflag_q;
        ce_d    = 1'b0;
        div_d   = div_q;

        if (sync) begin
            cnt_d = '0;
            div_d = 1'b0;
            if (cfg_we) begin
                act_d   = new_div;
                pnd_d   = new_div;
                pflag_d = 1'b0;
            end else if (pflag_q) begin
                act_d   = pnd_q;
                pflag_d = 1'b0;
            end
        end else if (en) begin
            cnt_d = term ? '0 : cnt_q + ONE;
            ce_d  = term;
            div_d = (half_t'(cnt_q) < half_w);
            if (term) begin
                if (cfg_we) begin
                    act_d   = new_div;
                    pnd_d   = new_div;
                    pflag_d = 1'b0;
                end else if (pflag_q) begin
                    act_d   = pnd_q;
                    pflag_d = 1'b0;
                end
            end else if (cfg_we) begin
                pnd_d   = new_div;
                pflag_d = 1'b1;
            end
        end else if (cfg_we) begin
            pnd_d   = new_div;
            pflag_d = 1'b1;
        end
    end

    // State and output registers; reset wins over everything.
    always_ff @(posedge in_clk) begin
        if (rst) begin
            cnt_q   <= '0;
            act_q   <= DEF_VAL;
            pnd_q   <= DEF_VAL;
            pflag_q <= 1'b0;
            ce_q    <= 1'b0;
            div_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            pnd_q   <= pnd_d;
            pflag_q <= pflag_d;
            ce_q    <= ce_d;
            div_q   <= div_d;
        end
    end

    assign cfg_pend = pflag_q;
    assign ce_out   = ce_q;
    assign div_out  = div_q;

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock-enable generator (strobe + square wave per channel).
// Latency: all outputs registered; one cycle from the computing edge.
// Backpressure: none; en stalls all channels, sync re-phases all channels together.
module clk_div_gen
    import clk_div_pkg::*;
#(
    parameter int N_CH    = 2,
    parameter int DIV_W   = DIV_W_DEF,
    parameter int DEF_DIV = 4
) (
    input  logic             in_clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic [N_CH-1:0]  cfg_we,
    input  logic [DIV_W-1:0] cfg_div,
    output logic [N_CH-1:0]  cfg_pend,
    output logic [N_CH-1:0]  ce_out,
    output logic [N_CH-1:0]  div_out
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        clk_div_ch #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .in_clk   (in_clk),
            .rst      (rst),
            .en       (en),
            .sync     (sync),
            .cfg_we   (cfg_we[i]),
            .cfg_div  (cfg_div),
            .cfg_pend (cfg_pend[i]),
            .ce_out   (ce_out[i]),
            .div_out  (div_out[i])
        );
    end

endmodule

// File: tb/tb_clk_div_gen.sv
// Randomised bench for clk_div_gen with a period-position reference model and scoreboard.
// Latency: expectations are queued per edge and checked just after that edge.
// Backpressure: n/a.
module tb_clk_div_gen;

    localparam int N_CH    = 2;
    localparam int DIV_W   = 8;
    localparam int DEF_DIV = 4;

    logic             in_clk;
    logic             rst;
    logic             en;
    logic             sync;
    logic [N_CH-1:0]  cfg_we;
    logic [DIV_W-1:0] cfg_div;
    logic [N_CH-1:0]  cfg_pend;
    logic [N_CH-1:0]  ce_out;
    logic [N_CH-1:0]  div_out;

    clk_div_gen #(
        .N_CH    (N_CH),
        .DIV_W   (DIV_W),
        .DEF_DIV (DEF_DIV)
    ) dut (
        .in_clk   (in_clk),
        .rst      (rst),
        .en       (en),
        .sync     (sync),
        .cfg_we   (cfg_we),
        .cfg_div  (cfg_div),
        .cfg_pend (cfg_pend),
        .ce_out   (ce_out),
        .div_out  (div_out)
    );

    initial begin
        in_clk = 1'b0;
        forever #5 in_clk = ~in_clk;
    end

    typedef struct {
        logic [N_CH-1:0] ce;
        logic [N_CH-1:0] dv;
        logic [N_CH-1:0] pd;
    } exp_t;

    exp_t sbq[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: position within the current period, period length,
    // the ratio waiting for the next boundary, and the last square-wave level.
    int pos   [N_CH];
    int per   [N_CH];
    int want  [N_CH];
    bit waitf [N_CH];
    bit lvl   [N_CH];

    // Apply one edge of stimulus and queue what the outputs must show after it.
    task automatic step(input bit r, input bit e, input bit s,
                        input logic [N_CH-1:0] we, input int v);
        exp_t x;
        int   nv;
        @(negedge in_clk);
        rst     = r;
        en      = e;
        sync    = s;
        cfg_we  = we;
        cfg_div = DIV_W'(v);
        nv      = (v % 256 == 0) ? 1 : v % 256;
        for (int i = 0; i < N_CH; i++) begin
            x.ce[i] = 1'b0;
            if (r) begin
                pos[i] = 0; per[i] = DEF_DIV; want[i] = DEF_DIV;
                waitf[i] = 0; lvl[i] = 0;
            end else if (s) begin
                pos[i] = 0; lvl[i] = 0;
                if (we[i]) begin
                    per[i] = nv; want[i] = nv; waitf[i] = 0;
                end else if (waitf[i]) begin
                    per[i] = want[i]; waitf[i] = 0;
                end
            end else if (e) begin
                // First half of the period (rounded up) is high.
                lvl[i]  = (pos[i] < (per[i] + 1) / 2);
                x.ce[i] = (pos[i] == per[i] - 1);
                if (x.ce[i]) begin
                    pos[i] = 0;
                    if (we[i]) begin
                        per[i] = nv; want[i] = nv; waitf[i] = 0;
                    end else if (waitf[i]) begin
                        per[i] = want[i]; waitf[i] = 0;
                    end
                end else begin
                    pos[i] = pos[i] + 1;
                    if (we[i]) begin
                        want[i] = nv; waitf[i] = 1;
                    end
                end
            end else if (we[i]) begin
                want[i] = nv; waitf[i] = 1;
            end
            x.dv[i] = lvl[i];
            x.pd[i] = waitf[i];
        end
        sbq.push_back(x);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step(0, 1, 0, '0, 0);
    endtask

    // Monitor: pop one expectation per edge and compare against the outputs.
    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge in_clk);
            #1;
            if (sbq.size() > 0) begin
                x = sbq.pop_front();
                vectors++;
                if (ce_out !== x.ce || div_out !== x.dv || cfg_pend !== x.pd) begin
                    miscompares++;
                    $display("FAIL outputs @%0t: ce=%b div=%b pend=%b, expected ce=%b div=%b pend=%b",
                             $time, ce_out, div_out, cfg_pend, x.ce, x.dv, x.pd);
                end
            end
        end
    end

    initial begin : driver
        int guard;
        rst = 1'b1; en = 1'b0; sync = 1'b0; cfg_we = '0; cfg_div = '0;

        // Reset state, then default ratio of 4 on both channels.
        step(1, 0, 0, '0, 0);
        step(1, 1, 0, '0, 0);
        run(12);

        // ch0 = 5 pending, ch1 = 3 written through on the sync edge.
        step(0, 1, 0, 2'b01, 5);
        step(0, 1, 1, 2'b10, 3);
        run(16);

        // Mid-period write of 6 to ch0 while D = 4, cnt = 1.
        step(1, 0, 0, '0, 0);
        step(0, 1, 0, '0, 0);
        step(0, 1, 0, 2'b01, 6);
        run(14);

        // Terminal-edge write of 0 on ch0: write-through, runs as divide-by-1.
        step(1, 0, 0, '0, 0);
        run(3);
        step(0, 1, 0, 2'b01, 0);
        run(6);

        // Freeze mid-period for 3 cycles.
        step(1, 0, 0, '0, 0);
        run(2);
        for (int k = 0; k < 3; k++) step(0, 0, 0, '0, 0);
        run(6);

        // Random phases and ratios, then sync, then reset mid-period.
        step(0, 1, 0, 2'b01, 7);
        run(3);
        step(0, 1, 0, 2'b10, 5);
        run($urandom_range(1, 9));
        step(0, 1, 1, '0, 0);
        run(10);
        step(1, 1, 0, '0, 0);
        run(6);

        // Largest ratio to exercise the ceil(D/2) width.
        step(0, 1, 1, 2'b11, 255);
        run(260);

        // Randomised traffic.
        for (int k = 0; k < 3000; k++) begin
            logic [N_CH-1:0] we;
            int v;
            for (int i = 0; i < N_CH; i++) we[i] = ($urandom_range(0, 15) == 0);
            v = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 9);
            step($urandom_range(0, 299) == 0, $urandom_range(0, 4) != 0,
                 $urandom_range(0, 59) == 0, we, v);
        end

        @(negedge in_clk);
        cfg_we = '0; sync = 1'b0;
        guard = 0;
        while (sbq.size() > 0 && guard < 20) begin
            @(negedge in_clk);
            guard++;
        end
        if (sbq.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
